alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end that serialises operations onto one shared, registered ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic [3:0]  req0_aluop,
    input  logic [3:0]  req1_aluop,
    output logic        resp0_valid,
    output logic        resp1_valid,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic [31:0] alu_operand_1,
    output logic [31:0] alu_operand_2,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
    state_t state, state_next;
    logic gid, gnt0, gnt1, accept, take;
`ifdef ALU_ARB_RR_EN
    logic ptr;
    assign gnt1 = req1_valid & (~req0_valid | ptr);
`else
    assign gnt1 = req1_valid & ~req0_valid;
`endif
    assign gnt0   = req0_valid & ~gnt1;
    assign accept = state == IDLE && (gnt0 || gnt1);
    // only the granted requester's ready can release the response
    assign take   = gid ? resp1_ready : resp0_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? EXEC : IDLE;
            EXEC:    state_next = CAPT;
            CAPT:    state_next = RESP;
            RESP:    state_next = take ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = rst && state == IDLE && gnt0;
        req1_ready  = rst && state == IDLE && gnt1;
        resp0_valid = state == RESP && !gid;
        resp1_valid = state == RESP && gid;
        busy        = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_operand_1 <= '0;
            alu_operand_2 <= '0;
            alu_op        <= '0;
            gid           <= 1'b0;
            resp_result   <= '0;
            resp_zero     <= 1'b0;
        end else if (accept) begin
            alu_operand_1 <= gnt1 ? req1_op1 : req0_op1;
            alu_operand_2 <= gnt1 ? req1_op2 : req0_op2;
            alu_op        <= gnt1 ? req1_aluop : req0_aluop;
            gid           <= gnt1;
        end else if (state == CAPT) begin
            resp_result   <= alu_result;
            resp_zero     <= alu_zero;
        end
    end

`ifdef ALU_ARB_RR_EN
    // pointer moves only when a response completes, never on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      ptr <= 1'b0;
        else if (state == RESP && take) ptr <= ~gid;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a registered ALU model.
// Expectations follow ALU_ARB_RR_EN when the bench is built with it defined.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [3:0]  req0_aluop = '0, req1_aluop = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [31:0] alu_operand_1, alu_operand_2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic        busy;
    int checks = 0;
    int errors = 0;
    logic exp_g [4];

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req0_aluop(req0_aluop), .req1_aluop(req1_aluop),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: 0 add, 1 sub, 2 and, 3 or; result registered one clock later
    always @(posedge clk) begin
        logic [31:0] r;
        case (alu_op)
            4'd0:    r = alu_operand_1 + alu_operand_2;
            4'd1:    r = alu_operand_1 - alu_operand_2;
            4'd2:    r = alu_operand_1 & alu_operand_2;
            default: r = alu_operand_1 | alu_operand_2;
        endcase
        alu_result <= r;
        alu_zero   <= r == 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ALU_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        #2;
        req0_valid = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd3; req0_aluop = 4'd0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_alu_op1", alu_operand_1, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        // single op: 5 + 3
        chk("single_req0_ready", 32'(req0_ready), 32'd1);
        chk("single_req1_ready", 32'(req1_ready), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_exec_busy", 32'(busy), 32'd1);
        chk("single_exec_ready", 32'(req0_ready), 32'd0);
        chk("single_alu_op1", alu_operand_1, 32'd5);
        chk("single_alu_op2", alu_operand_2, 32'd3);
        tick();
        chk("single_capt_valid", 32'(resp0_valid), 32'd0);
        tick();
        chk("single_resp_valid", 32'(resp0_valid), 32'd1);
        chk("single_result", resp_result, 32'd8);
        chk("single_zero", 32'(resp_zero), 32'd0);
        tick();
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("single_done_valid", 32'(resp0_valid), 32'd0);
        // zero flag: 7 - 7 from requester 1
        req1_valid = 1'b1; req1_op1 = 32'd7; req1_op2 = 32'd7; req1_aluop = 4'd1;
        #1;
        chk("zero_req1_ready", 32'(req1_ready), 32'd1);
        chk("zero_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        chk("zero_resp1_valid", 32'(resp1_valid), 32'd1);
        chk("zero_resp0_valid", 32'(resp0_valid), 32'd0);
        chk("zero_result", resp_result, 32'd0);
        chk("zero_flag", 32'(resp_zero), 32'd1);
        tick();
        chk("zero_done_busy", 32'(busy), 32'd0);
        // contention: req0 1+1, req1 4|2, both held valid
        req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_aluop = 4'd0;
        req1_valid = 1'b1; req1_op1 = 32'd4; req1_op2 = 32'd2; req1_aluop = 4'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont%0d_req0_ready", i), 32'(req0_ready), 32'(!exp_g[i]));
            chk($sformatf("cont%0d_req1_ready", i), 32'(req1_ready), 32'(exp_g[i]));
            tick();
            tick();
            tick();
            chk($sformatf("cont%0d_resp0_valid", i), 32'(resp0_valid), 32'(!exp_g[i]));
            chk($sformatf("cont%0d_resp1_valid", i), 32'(resp1_valid), 32'(exp_g[i]));
            chk($sformatf("cont%0d_result", i), resp_result, exp_g[i] ? 32'd6 : 32'd2);
            tick();
        end
        // backpressure: req0 10 + 20, resp0_ready low for 5 cycles, req1 pending
        req0_op1 = 32'd10; req0_op2 = 32'd20; resp0_ready = 1'b0;
        #1;
        chk("bp_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        chk("bp_resp0_valid", 32'(resp0_valid), 32'd1);
        chk("bp_result", resp_result, 32'd30);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d_valid", i), 32'(resp0_valid), 32'd1);
            chk($sformatf("bp%0d_result", i), resp_result, 32'd30);
            chk($sformatf("bp%0d_busy", i), 32'(busy), 32'd1);
            chk($sformatf("bp%0d_req1_ready", i), 32'(req1_ready), 32'd0);
        end
        req1_valid = 1'b0;
        resp0_ready = 1'b1;
        tick();
        chk("bp_done_busy", 32'(busy), 32'd0);
        chk("bp_done_valid", 32'(resp0_valid), 32'd0);
        // reset while in EXEC
        req1_valid = 1'b1; req1_op1 = 32'd9; req1_op2 = 32'd1; req1_aluop = 4'd0;
        tick();
        req1_valid = 1'b0;
        chk("rexec_busy", 32'(busy), 32'd1);
        chk("rexec_alu_op1", alu_operand_1, 32'd9);
        #2;
        rst = 1'b0;
        #1;
        chk("rexec_rst_busy", 32'(busy), 32'd0);
        chk("rexec_rst_alu_op1", alu_operand_1, 32'd0);
        chk("rexec_rst_alu_op2", alu_operand_2, 32'd0);
        chk("rexec_rst_result", resp_result, 32'd0);
        chk("rexec_rst_resp1", 32'(resp1_valid), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rexec%0d_resp1", i), 32'(resp1_valid), 32'd0);
            chk($sformatf("rexec%0d_busy", i), 32'(busy), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
